// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipelined core.
// Owns the architectural PC, issues ready-handshake instruction-memory
// requests, fills the IF/ID register and absorbs hazard stalls with a
// one-entry skid buffer. Taken-branch redirects from decode either retarget
// the PC at once or, when a request is still outstanding, wait for it to
// complete and discard its data (DROP).
// Optional feature macro: FETCH_HLT_STOP_EN -- stop fetching on a HLT word
// (opcode 4'b1111) and hold in HALT until a redirect or reset.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] BUBBLE_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus2,
  output logic        halted
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

`ifdef FETCH_HLT_STOP_EN
  localparam logic HLT_EN = 1'b1;
`else
  localparam logic HLT_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drop_pc_q, drop_pc_d;
  logic [15:0] skid_inst_q, skid_inst_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] ifid_inst_q, ifid_inst_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic [15:0] ifid_pc2_q, ifid_pc2_d;
  logic        halted_q, halted_d;

  // HLT opcode detection; always false when the halt feature is compiled out.
  function automatic logic is_hlt(input logic [15:0] word);
    return HLT_EN && (word[15:12] == 4'b1111);
  endfunction

  // Requests are only made in FETCH and DROP. In DROP the PC has not been
  // moved yet, so it still holds the address of the outstanding request.
  assign imem_req  = !rst && ((state_q == FETCH) || (state_q == DROP));
  assign imem_addr = pc_q;

  assign ifid_valid    = ifid_valid_q;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus2 = ifid_pc2_q;
  assign halted        = halted_q;

  // Next-state logic: redirect beats stall, stall beats normal flow.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_pc_d    = drop_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc2_d   = ifid_pc2_q;
    halted_d     = halted_q;

    if (redirect_valid) begin
      // Flush IF/ID; leaving HOLD implicitly discards the skid entry.
      ifid_valid_d = 1'b0;
      ifid_inst_d  = BUBBLE_INST;
      halted_d     = 1'b0;
      if (((state_q == FETCH) || (state_q == DROP)) && !imem_rdy) begin
        // Outstanding request must finish on its own address first.
        drop_pc_d = redirect_pc;
        state_d   = DROP;
      end else begin
        pc_d    = redirect_pc;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_rdy) begin
            if (!stall) begin
              ifid_valid_d = 1'b1;
              ifid_inst_d  = imem_data;
              ifid_pc_d    = pc_q;
              ifid_pc2_d   = pc_q + 16'd2;
              if (is_hlt(imem_data)) begin
                state_d  = HALT;
                halted_d = 1'b1;
              end else begin
                pc_d = pc_q + 16'd2;
              end
            end else begin
              skid_inst_d = imem_data;
              skid_pc_d   = pc_q;
              pc_d        = pc_q + 16'd2;
              state_d     = HOLD;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = BUBBLE_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_inst_d  = skid_inst_q;
            ifid_pc_d    = skid_pc_q;
            ifid_pc2_d   = skid_pc_q + 16'd2;
            state_d      = FETCH;
            if (is_hlt(skid_inst_q)) begin
              // PC already advanced at capture time; pull it back to the HLT.
              pc_d     = skid_pc_q;
              state_d  = HALT;
              halted_d = 1'b1;
            end
          end
        end
        DROP: begin
          if (imem_rdy) begin
            pc_d    = drop_pc_q;
            state_d = FETCH;
          end
        end
`ifdef FETCH_HLT_STOP_EN
        HALT: begin
          state_d = HALT;
        end
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  // Control state, PC and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= BUBBLE_INST;
      ifid_pc_q    <= 16'h0000;
      ifid_pc2_q   <= 16'h0000;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc2_q   <= ifid_pc2_d;
      halted_q     <= halted_d;
    end
  end

  // Skid buffer and pending redirect target: data only, qualified by state.
  always_ff @(posedge clk) begin
    drop_pc_q   <= drop_pc_d;
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: configurable-latency memory returning
// addr ^ 16'hA000, with a scoreboard of expected IF/ID loads.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        ifid_valid;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus2;
  logic        halted;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc(ifid_pc),
    .ifid_pc_plus2(ifid_pc_plus2), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory model: rdy on the lat-th cycle of a request.
  int   lat = 1;
  int   wait_cnt = 0;
  logic hlt_on = 1'b0;
  assign imem_rdy  = imem_req && ((wait_cnt + 1) >= lat);
  assign imem_data = (hlt_on && imem_addr == 16'h0010) ? 16'hF000 : (imem_addr ^ 16'hA000);
  always @(posedge clk) wait_cnt <= (imem_req && !imem_rdy) ? wait_cnt + 1 : 0;

  typedef struct packed { logic [15:0] pc; logic [15:0] inst; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] mon_p2;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en = 1'b1;
  logic load_seen = 1'b0;

  // An IF/ID load can only happen on an edge where stall and rst were low.
  always @(posedge clk) load_seen <= !stall && !rst;

  always @(negedge clk) begin
    if (mon_en && load_seen && ifid_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ifid_unexpected: got pc=%h inst=%h, expected no load", ifid_pc, ifid_inst);
      end else begin
        mon_e  = sb.pop_front();
        mon_p2 = mon_e.pc + 16'd2;
        if (ifid_pc !== mon_e.pc || ifid_inst !== mon_e.inst || ifid_pc_plus2 !== mon_p2) begin
          n_fail++;
          $display("FAIL ifid_load: got pc=%h inst=%h p2=%h, expected pc=%h inst=%h p2=%h",
                   ifid_pc, ifid_inst, ifid_pc_plus2, mon_e.pc, mon_e.inst, mon_p2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (3) begin
      tick();
      n_tests++;
      if (imem_req !== 1'b0) begin
        n_fail++; $display("FAIL reset_req: got %b, expected 0", imem_req);
      end
    end
    n_tests++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 16'h0000 || ifid_pc !== 16'h0000 ||
        ifid_pc_plus2 !== 16'h0000 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got v=%b inst=%h pc=%h p2=%h h=%b, expected 0 0000 0000 0000 0",
               ifid_valid, ifid_inst, ifid_pc, ifid_pc_plus2, halted);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h, expected 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    lat = 1;
    for (int i = 0; i < 3; i++) sb.push_back({16'(2 * i), 16'(2 * i) ^ 16'hA000});
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ifid_valid !== 1'b1 || imem_addr !== 16'(2 * (i + 1))) begin
        n_fail++;
        $display("FAIL zero_wait_%0d: got v=%b addr=%h, expected 1 %h", i, ifid_valid, imem_addr, 16'(2 * (i + 1)));
      end
    end
  endtask

  task automatic test_stall();
    lat = 3; stall = 1'b1;
    tick();
    n_tests++;
    if (imem_addr !== 16'h0006 || ifid_valid !== 1'b1 || ifid_pc !== 16'h0004) begin
      n_fail++; $display("FAIL stall_wait: got addr=%h v=%b pc=%h, expected 0006 1 0004", imem_addr, ifid_valid, ifid_pc);
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 16'h0004 || ifid_inst !== 16'hA004) begin
        n_fail++;
        $display("FAIL hold_%0d: got req=%b v=%b pc=%h inst=%h, expected 0 1 0004 A004",
                 i, imem_req, ifid_valid, ifid_pc, ifid_inst);
      end
      if (i == 0) tick();
    end
    stall = 1'b0;
    sb.push_back({16'h0006, 16'hA006});
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
      n_fail++; $display("FAIL stall_release: got req=%b addr=%h, expected 1 0008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drop();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || ifid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_pending_%0d: got req=%b addr=%h v=%b, expected 1 0008 0", i, imem_req, imem_addr, ifid_valid);
      end
      tick();
    end
    n_tests++;
    if (imem_addr !== 16'h0100 || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_target: got addr=%h v=%b, expected 0100 0", imem_addr, ifid_valid);
    end
    sb.push_back({16'h0100, 16'hA100});
    repeat (3) tick();
    n_tests++;
    if (imem_addr !== 16'h0102) begin
      n_fail++; $display("FAIL drop_resume: got addr=%h, expected 0102", imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    lat = 1; stall = 1'b1;
    tick();
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rs_hold: got req=%b, expected 0", imem_req);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    n_tests++;
    if (ifid_valid !== 1'b0 || ifid_inst !== 16'h0000 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
      n_fail++;
      $display("FAIL rs_flush: got v=%b inst=%h req=%b addr=%h, expected 0 0000 1 0200",
               ifid_valid, ifid_inst, imem_req, imem_addr);
    end
    redirect_valid = 1'b0; stall = 1'b0;
    sb.push_back({16'h0200, 16'hA200});
    tick();
    n_tests++;
    if (imem_addr !== 16'h0202) begin
      n_fail++; $display("FAIL rs_next: got addr=%h, expected 0202", imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (imem_addr !== 16'hFFFE || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_target: got addr=%h v=%b, expected FFFE 0", imem_addr, ifid_valid);
    end
    sb.push_back({16'hFFFE, 16'h5FFE});
    tick();
    n_tests++;
    if (imem_addr !== 16'h0000 || ifid_pc_plus2 !== 16'h0000) begin
      n_fail++; $display("FAIL wrap: got addr=%h p2=%h, expected 0000 0000", imem_addr, ifid_pc_plus2);
    end
  endtask

  task automatic test_hlt();
    hlt_on = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (imem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL hlt_target: got addr=%h, expected 0010", imem_addr);
    end
    sb.push_back({16'h0010, 16'hF000});
`ifdef FETCH_HLT_STOP_EN
    tick();
    n_tests++;
    if (halted !== 1'b1 || ifid_pc !== 16'h0010 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL hlt_stop: got h=%b pc=%h req=%b, expected 1 0010 0", halted, ifid_pc, imem_req);
    end
    @(negedge clk);
    #1 mon_en = 1'b0;
    tick();
    n_tests++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL hlt_hold: got h=%b req=%b, expected 1 0", halted, imem_req);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040 || ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_resume: got h=%b req=%b addr=%h v=%b, expected 0 1 0040 0", halted, imem_req, imem_addr, ifid_valid);
    end
    mon_en = 1'b1;
    sb.push_back({16'h0040, 16'hA040});
    tick();
`else
    sb.push_back({16'h0012, 16'hA012});
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'(16'h0012 + 2 * i)) begin
        n_fail++;
        $display("FAIL hlt_ignored_%0d: got h=%b req=%b addr=%h, expected 0 1 %h",
                 i, halted, imem_req, imem_addr, 16'(16'h0012 + 2 * i));
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    test_hlt();
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending loads, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the 16-bit pipelined core. It owns the architectural PC register, issues instruction-memory requests over a ready-based handshake, and fills the IF/ID pipeline register. It sits directly upstream of the decode-stage PC/branch control, which consumes `ifid_inst`/`ifid_pc` and returns a taken-branch redirect. It honours the hazard-unit stall with a one-entry skid buffer.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `BUBBLE_INST`, 16'h0000, value driven on `ifid_inst` when IF/ID is invalid.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 16: fetch address; stable while `imem_req` is high and `imem_rdy` is low.
- `imem_rdy` in 1: data valid for the current request; may assert in the request cycle (zero-wait).
- `imem_data` in 16: instruction word, sampled when `imem_req & imem_rdy`.
- `redirect_valid` in 1: taken branch/BR from decode.
- `redirect_pc` in 16: branch target.
- `stall` in 1: hold IF/ID (hazard unit).
- `ifid_valid` out 1, `ifid_inst` out 16, `ifid_pc` out 16, `ifid_pc_plus2` out 16: IF/ID register contents.
- `halted` out 1: fetch is stopped on HLT.

## Operation
- States: FETCH, HOLD, DROP, HALT.
- Registers: `pc`, `drop_pc`, skid buffer {`skid_inst`, `skid_pc`}, and the IF/ID fields.
- `imem_req` is 1 only in FETCH and DROP, never while `rst` is high.
- `imem_addr` is `pc` in FETCH and the old pending address in DROP.
- All PC arithmetic is 16-bit modulo; 16'hFFFE + 2 = 16'h0000.
- Event priority each cycle: `rst`, then `redirect_valid`, then `stall`, then normal flow.

FETCH:
- `rdy & !stall`: IF/ID gets {1, `imem_data`, `pc`, `pc`+2}; `pc` <= `pc`+2.
- `rdy & stall`: the word goes into the skid buffer; `pc` <= `pc`+2; go to HOLD. IF/ID holds.
- `!rdy & !stall`: `ifid_valid` <= 0 (bubble).
- `!rdy & stall`: IF/ID holds.

HOLD:
- No request is issued.
- When `stall` falls, IF/ID is loaded from the skid buffer and the state returns to FETCH.

Redirect (any state):
- `ifid_valid` <= 0 and `ifid_inst` <= `BUBBLE_INST`; the skid buffer is discarded.
- In FETCH with a request pending (`!rdy`): `drop_pc` <= `redirect_pc`, go to DROP. The address stays on the old PC.
- Otherwise (including `rdy` in the same cycle, whose data is discarded): `pc` <= `redirect_pc`, go to FETCH.

DROP:
- Waits for `imem_rdy` and discards the data. Then `pc` <= `drop_pc` and the state goes to FETCH.
- A new redirect while in DROP overwrites `drop_pc`.

## Timing
- Reset values: `pc`=`RESET_PC`, state FETCH, `ifid_valid`=0, `ifid_inst`=`BUBBLE_INST`, `ifid_pc`=0, `ifid_pc_plus2`=0, `halted`=0, `imem_req`=0.
- The first request is issued in the first cycle after `rst` falls.
- IF/ID is valid in the cycle after `imem_rdy`.
- With zero-wait memory, throughput is one instruction per cycle.
- The redirect target appears on `imem_addr` in the cycle after `redirect_valid`, or the cycle after the dropped `rdy`.
- Reset asserted mid-request abandons the request. Memory must tolerate `imem_req` falling without `rdy`.
- All outputs are registered except `imem_req` and `imem_addr`, which are decoded from state and registers.

## Configuration
`FETCH_HLT_STOP_EN`:
- Defined:
  - When a word with `[15:12]`=4'b1111 is loaded into IF/ID, the state goes to HALT and `pc` is not advanced past it.
  - In HALT, `imem_req`=0 and `halted`=1.
  - A redirect in HALT clears `halted` and resumes via the normal redirect rules. This covers a HLT fetched in the shadow of a taken branch.
  - `rst` also exits HALT.
- Undefined:
  - The HALT state is absent and `halted` is tied to 0.
  - HLT words are fetched like any other instruction and PC+2 fetching continues.

## Test plan
- Reset, zero-wait memory returning `addr`^16'hA000. Required: IF/ID shows pc 0,2,4 on consecutive cycles starting one cycle after the first request, with insts A000,A002,A004.
- 3-cycle memory, `stall` high during `rdy` at pc 0x0006, released 2 cycles later. Required: HOLD with `imem_req`=0 and IF/ID unchanged; on release IF/ID gets pc 0x0006; the next request is 0x0008.
- `redirect_valid`, `redirect_pc`=0x0100 while a request to 0x0008 is pending on 3-cycle memory. Required: `imem_addr` stays 0x0008 until `rdy`; the data is dropped; the next request is 0x0100; `ifid_valid`=0 throughout.
- `redirect_valid` and `stall` in the same cycle. Required: IF/ID is flushed (`ifid_valid`=0), the skid buffer is empty, and the next request is to `redirect_pc`.
- `FETCH_HLT_STOP_EN`: 16'hF000 at 0x0010. Required: `halted`=1 with `ifid_pc`=0x0010 and no further requests. A redirect to 0x0040 then gives `halted`=0 and a request to 0x0040.
- Start with `pc` at 0xFFFE. Required: the next fetch address is 0x0000 and `ifid_pc_plus2`=0x0000.
